fetch_queue: RTL and testbench

Instruction-fetch stage with a small prefetch FIFO. It sits between instruction memory and the decode stage, replacing the single-entry fetch buffer. It owns the fetch PC and prefetches sequential words into a queue. Decode consumes from the queue under a valid/ready handshake. An execute-stage redirect (taken branch or JAL) squashes every queued and in-flight word and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and queue entry layout for the fetch stage.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (see fetch_queue.sv).
package fetch_pkg;

  localparam int unsigned DBITS_DEFAULT        = 32;
  localparam logic [31:0] START_PC_DEFAULT     = 32'h40;
  localparam int unsigned IMEM_ADDR_BITS_DEFAULT = 11;
  localparam int unsigned DEPTH_DEFAULT        = 4;

  // One prefetched word and the address of the word that follows it.
  typedef struct packed {
    logic [DBITS_DEFAULT-1:0] inst;
    logic [DBITS_DEFAULT-1:0] pc_inc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch entry storage: circular buffer with read/write pointers and count.
// clear has priority over push/pop; storage is not cleared by it.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Next-state for pointers, count and storage.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; storage resets to zero so the head is never X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, prefetches sequential words
// into fetch_fifo and presents the head to decode under valid/ready.
// A redirect squashes all queued words and restarts fetch at the target.
// Define FETCH_QUEUE_BYPASS_EN to forward the fetched word straight to decode
// when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DBITS               = DBITS_DEFAULT,
  parameter logic [DBITS-1:0]  START_PC            = DBITS'(START_PC_DEFAULT),
  parameter int unsigned       IMEM_ADDR_BIT_WIDTH = IMEM_ADDR_BITS_DEFAULT,
  parameter int unsigned       DEPTH               = DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           redirect_valid,
  input  logic [DBITS-1:0]               redirect_pc,
  output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
  input  logic [DBITS-1:0]               imem_data,
  output logic                           out_valid,
  output logic [DBITS-1:0]               out_inst,
  output logic [DBITS-1:0]               out_pc_inc,
  input  logic                           out_ready
);

  typedef struct packed {
    logic [DBITS-1:0] inst;
    logic [DBITS-1:0] pc_inc;
  } entry_t;

  logic [DBITS-1:0] pc_q, pc_d;
  logic [DBITS-1:0] pc_inc;
  entry_t           fetch_entry;
  entry_t           fifo_head;
  entry_t           head;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic             pop, fetch;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .EW    ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (redirect_valid),
    .wdata (fetch_entry),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign imem_addr  = pc_q[IMEM_ADDR_BIT_WIDTH+1:2];
  assign out_inst   = head.inst;
  assign out_pc_inc = head.pc_inc;

  // Arbitration: redirect beats push and pop; push allowed when a slot is
  // free or the head leaves this cycle.
  always_comb begin
    pc_inc      = pc_q + DBITS'(4);
    fetch_entry = '{inst: imem_data, pc_inc: pc_inc};
    head        = fifo_head;
    out_valid   = ~fifo_empty & ~redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (fifo_empty) begin
      head      = fetch_entry;
      out_valid = ~redirect_valid;
    end
`endif
    pop       = out_valid & out_ready;
    fifo_pop  = pop & ~fifo_empty;
    fetch     = ~redirect_valid & (~fifo_full | pop);
    fifo_push = fetch;
`ifdef FETCH_QUEUE_BYPASS_EN
    // A bypassed word consumed by decode never enters the queue.
    if (fifo_empty & pop) begin
      fifo_push = 1'b0;
    end
`endif
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[DBITS-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_inc;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= START_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// checked against a queue-level reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc_inc;
  logic        out_ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc_inc;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mpc;
  bit          last_ev;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  assign imem_data = 32'hA000_0000 + 32'(imem_addr);

  fetch_queue #(
    .DBITS               (32),
    .START_PC            (32'h40),
    .IMEM_ADDR_BIT_WIDTH (11),
    .DEPTH               (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc_inc     (out_pc_inc),
    .out_ready      (out_ready)
  );

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return 32'hA000_0000 + {21'b0, pc[12:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, let them settle, compare against the model's prediction.
  task automatic drive(input bit rv, input logic [31:0] rpc, input bit rdy);
    ment_t eh;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    last_ev = !rv && (mq.size() > 0 || BYP);
    chk("imem_addr", 32'(imem_addr), {21'b0, mpc[12:2]});
    chk("out_valid", 32'(out_valid), 32'(last_ev));
    if (last_ev) begin
      if (mq.size() > 0) eh = mq[0];
      else eh = '{inst: imem(mpc), pc_inc: mpc + 32'd4};
      chk("out_inst", out_inst, eh.inst);
      chk("out_pc_inc", out_pc_inc, eh.pc_inc);
    end else begin
      chk("head_not_x", 32'($isunknown({out_inst, out_pc_inc})), 32'd0);
    end
  endtask

  task automatic dc(input bit rv, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    drive(rv, rpc, rdy);
  endtask

  // Advance the model across one rising edge.
  task automatic tick();
    bit    pop, fetch;
    int    sz;
    ment_t e;
    @(posedge clk);
    if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      pop   = last_ev && out_ready;
      sz    = mq.size();
      fetch = (sz < DEPTH) || pop;
      e     = '{inst: imem(mpc), pc_inc: mpc + 32'd4};
      if (pop && sz > 0) void'(mq.pop_front());
      if (fetch) begin
        if (!(BYP && sz == 0 && pop)) mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    dc(rv, rpc, rdy);
    tick();
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 32'h40;
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state, then release and stream with out_ready=1.
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc_inc", out_pc_inc, 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h10);
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
`ifndef FETCH_QUEUE_BYPASS_EN
    tick();
    dc(1'b0, '0, 1'b1);
`endif
    chk("first_inst", out_inst, 32'hA000_0010);
    chk("first_pc_inc", out_pc_inc, 32'h44);
    tick();
    repeat (5) step(1'b0, '0, 1'b1);

    // Stall decode: queue fills, fetch halts with pc held.
    repeat (7) step(1'b0, '0, 1'b0);
    dc(1'b0, '0, 1'b0);
    chk("stall_addr_held", 32'(imem_addr), {21'b0, mpc[12:2]});
    tick();

    // Redirect while full and decode ready: no pop, target after latency.
    dc(1'b1, 32'h0000_0103, 1'b1);
    chk("redir_valid_low", 32'(out_valid), 32'd0);
    tick();
`ifndef FETCH_QUEUE_BYPASS_EN
    step(1'b0, '0, 1'b1);
`endif
    dc(1'b0, '0, 1'b1);
    chk("redir_pc_inc", out_pc_inc, 32'h104);
    chk("redir_inst", out_inst, 32'hA000_0040);
    tick();
    repeat (3) step(1'b0, '0, 1'b1);

    // Partial stall and drain in order.
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1);

    // Redirect to the top of the address space: pc wraps to 0.
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    dc(1'b0, '0, 1'b1);
    chk("wrap_addr_top", 32'(imem_addr), 32'h7FF);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("wrap_pc_inc", out_pc_inc, 32'h0);
`endif
    tick();
    dc(1'b0, '0, 1'b1);
    chk("wrap_addr_zero", 32'(imem_addr), 32'h0);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("wrap_pc_inc", out_pc_inc, 32'h0);
`endif
    tick();
    repeat (3) step(1'b0, '0, 1'b1);

    // Fill three entries, then assert reset between clock edges.
    step(1'b1, 32'h0000_0200, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_addr", 32'(imem_addr), 32'h10);
    chk("async_rst_inst", out_inst, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    tick();
    repeat (4) step(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) == 0, $urandom, ($urandom % 3) != 0);
    end
    repeat (DEPTH + 2) step(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
